// File: rtl/gray_sched_pkg.sv
// Shared constants and type definitions for the Gray-code conversion scheduler.
package gray_sched_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_N_REQ = 4;

  // Conversion direction selected per requester.
  typedef enum logic {
    MODE_B2G = 1'b0,
    MODE_G2B = 1'b1
  } mode_t;

  // Output register occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/gray_codec.sv
// Combinational binary<->Gray converter shared by all requesters.
module gray_codec
  import gray_sched_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  input  mode_t            mode,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] bin;

  // Gray->binary is a prefix XOR running from the MSB downward.
  always_comb begin
    // NOTE: every variable gets a value before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    bin          = '0;
    bin[WIDTH-1] = data[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ data[i];
    end
  end

  // Select the direction requested by the granted requester.
  always_comb begin
    result = data ^ (data >> 1);
    if (mode == MODE_G2B) begin
      result = bin;
    end
  end

endmodule

// File: rtl/gray_conv_scheduler.sv
// Round-robin scheduler sharing one Gray codec among N_REQ requesters, with a
// single registered output slot that can refill in the same cycle it drains.
module gray_conv_scheduler
  import gray_sched_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  input  logic [N_REQ-1:0]         req_mode,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  input  logic                     rsp_ready
);

  localparam int ID_W = $clog2(N_REQ);

  state_t            state;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   cand;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_found;
  logic              grant_ok;
  logic              grant;
  logic [WIDTH-1:0]  sel_data;
  mode_t             sel_mode;
  logic [WIDTH-1:0]  codec_result;

  assign rsp_valid = (state == ST_FULL);

  // The slot may be refilled when empty or when it drains this very cycle;
  // reset blocks any grant.
  assign grant_ok = !rst && ((state == ST_EMPTY) || rsp_ready);

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = ID_W'((int'(last_grant) + off) % N_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // One-hot grant, only when the output slot can take a new result.
  always_comb begin
    req_ready = '0;
    if (grant_ok && grant_found) begin
      for (int i = 0; i < N_REQ; i++) begin
        req_ready[i] = (grant_idx == ID_W'(i));
      end
    end
  end

  assign grant = |req_ready;

  // Route the granted requester's operand and mode into the shared codec.
  always_comb begin
    sel_data = '0;
    sel_mode = MODE_B2G;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) begin
        sel_data = req_data[i*WIDTH +: WIDTH];
        sel_mode = mode_t'(req_mode[i]);
      end
    end
  end

  gray_codec #(
    .WIDTH (WIDTH)
  ) u_codec (
    .data   (sel_data),
    .mode   (sel_mode),
    .result (codec_result)
  );

  // Output slot and arbitration pointer; a grant always wins over a drain so
  // back-to-back traffic keeps the slot full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_EMPTY;
      last_grant <= ID_W'(N_REQ - 1);
      rsp_data   <= '0;
      rsp_id     <= '0;
    end else if (grant) begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, so ordering inside this block does not matter.
      state      <= ST_FULL;
      last_grant <= grant_idx;
      rsp_data   <= codec_result;
      rsp_id     <= grant_idx;
    end else if (rsp_ready) begin
      state <= ST_EMPTY;
    end
  end

endmodule

// File: tb/tb_gray_conv_scheduler.sv
// Directed bench: stimulus pushes expected responses into a scoreboard queue,
// an independent monitor pops and compares on every response handshake.
module tb_gray_conv_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_mode;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [3:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        rsp_ready;

  typedef struct packed {
    logic [3:0] data;
    logic [1:0] id;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  gray_conv_scheduler #(
    .N_REQ (4),
    .WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_mode  (req_mode),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Present one request, wait for its grant, optionally record the expected
  // response, then withdraw every request after the accepting edge.
  task automatic issue(input logic [1:0] idx, input logic [3:0] data, input logic mode,
                       input logic [3:0] exp, input bit push, output int waited);
    waited = 0;
    req_valid[idx]         = 1'b1;
    req_data[idx*4 +: 4]   = data;
    req_mode[idx]          = mode;
    @(negedge clk);
    while (!req_ready[idx] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready[idx]) begin
      fail_now("grant_timeout");
    end else begin
      check("req_ready_onehot", 32'(req_ready), 32'(4'b0001 << idx));
      if (push) sb.push_back('{data: exp, id: idx});
    end
    @(posedge clk);
    #1;
    req_valid = '0;
  endtask

  // Scoreboard monitor: compare on every response handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_rsp");
        end else begin
          e = sb.pop_front();
          check("rsp_data", 32'(rsp_data), 32'(e.data));
          check("rsp_id", 32'(rsp_id), 32'(e.id));
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "simulation watchdog expired");
  end

  // Fairness vector: requester data, mode and expected result.
  logic [3:0] fair_data [4] = '{4'b1000, 4'b0110, 4'b1010, 4'b0001};
  logic       fair_mode [4] = '{1'b0,    1'b1,    1'b0,    1'b1};
  logic [3:0] fair_exp  [4] = '{4'b1100, 4'b0100, 4'b1111, 4'b0001};

  initial begin
    int         w;
    int         drain;
    logic [3:0] g;
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_data  = 16'hA5C3;
    req_mode  = 4'b0101;
    rsp_ready = 1'b1;

    // Reset state, with every requester asking.
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    req_valid = '0;
    rst       = 1'b0;

    // Single binary->Gray request from requester 0.
    issue(2'd0, 4'b0101, 1'b0, 4'b0111, 1'b1, w);
    check("first_grant_latency", 32'(w), 0);
    check("rsp_valid_after_accept", 32'(rsp_valid), 1);
    @(negedge clk);
    @(negedge clk);
    check("idle_rsp_valid", 32'(rsp_valid), 0);

    // Gray->binary from requester 2.
    @(posedge clk); #1;
    issue(2'd2, 4'b1111, 1'b1, 4'b1010, 1'b1, w);
    // Requester 3 moves the pointer so requester 0 leads the fairness run.
    issue(2'd3, 4'b0011, 1'b0, 4'b0010, 1'b1, w);

    // Fairness and wrap-around, one grant per cycle.
    for (int i = 0; i < 4; i++) begin
      req_data[i*4 +: 4] = fair_data[i];
      req_mode[i]        = fair_mode[i];
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("fair_req_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      check("fair_rsp_valid", 32'(rsp_valid), 1);
      sb.push_back('{data: fair_exp[k % 4], id: 2'(k % 4)});
      @(posedge clk); #1;
    end
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;

    // Stall: FULL with rsp_ready low while requester 1 waits.
    rsp_ready = 1'b0;
    issue(2'd0, 4'b1001, 1'b0, 4'b1101, 1'b1, w);
    req_valid[1]     = 1'b1;
    req_data[7:4]    = 4'b0100;
    req_mode[1]      = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_rsp_valid", 32'(rsp_valid), 1);
      check("stall_rsp_data", 32'(rsp_data), 32'(4'b1101));
      check("stall_rsp_id", 32'(rsp_id), 0);
      check("stall_req_ready", 32'(req_ready), 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    issue(2'd1, 4'b0100, 1'b0, 4'b0110, 1'b1, w);
    check("stall_release_same_cycle", 32'(w), 0);
    repeat (2) @(posedge clk);
    #1;

    // Reset while FULL discards the held response.
    rsp_ready = 1'b0;
    issue(2'd2, 4'b0111, 1'b0, 4'b0100, 1'b0, w);
    check("pre_reset_full", 32'(rsp_valid), 1);
    req_valid = 4'b1111;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_rsp_valid", 32'(rsp_valid), 0);
    check("async_rst_rsp_data", 32'(rsp_data), 0);
    check("async_rst_rsp_id", 32'(rsp_id), 0);
    check("async_rst_req_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    rst       = 1'b0;
    rsp_ready = 1'b1;
    issue(2'd0, 4'b1100, 1'b1, 4'b1000, 1'b1, w);
    check("post_reset_tie_latency", 32'(w), 0);
    repeat (2) @(posedge clk);
    #1;

    // Exhaustive codec round trip through rotating requesters.
    for (int x = 0; x < 16; x++) begin
      g = 4'(x) ^ (4'(x) >> 1);
      issue(2'(x % 4), 4'(x), 1'b0, g, 1'b1, w);
      issue(2'((x + 1) % 4), g, 1'b1, 4'(x), 1'b1, w);
    end

    // Drain the scoreboard with a bound.
    drain = 0;
    while (sb.size() != 0 && drain < 20) begin
      @(posedge clk);
      drain++;
    end
    @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
